// File: rtl/wb_arb_pkg.sv
// Shared constants and request type for the register-file write-port arbiter.
package wb_arb_pkg;
   localparam int DW = 32;
   localparam int AW = 5;
   localparam logic [AW-1:0] REG_ZERO = '0;

   typedef struct packed {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wb_req_t;
endpackage

// File: rtl/wb_pend_fifo.sv
// Register FIFO for pending MDU results; head visible combinationally, 1-cycle push-to-head.
// No internal backpressure: the owner gates push on count and pop on non-empty (or same-cycle bypass).
module wb_pend_fifo #(
   parameter int DW    = 32,
   parameter int AW    = 5,
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [AW-1:0]              push_dest,
   input  logic [DW-1:0]              push_data,
   input  logic                       pop,
   output logic [AW-1:0]              head_dest,
   output logic [DW-1:0]              head_data,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic [DEPTH-1:0]           ent_vld,
   output logic [DEPTH*AW-1:0]        ent_dest
);
   localparam int PTRW = $clog2(DEPTH);
   localparam int CW   = $clog2(DEPTH+1);

   logic [AW-1:0]   dest_q [DEPTH];
   logic [DW-1:0]   data_q [DEPTH];
   logic [PTRW-1:0] wr_ptr;
   logic [PTRW-1:0] rd_ptr;
   logic [CW-1:0]   cnt;
   logic [PTRW-1:0] off;

   // Push+pop on an empty FIFO is the owner's bypass: both pointers move, count holds.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTRW'(1);
         if (pop)  rd_ptr <= rd_ptr + PTRW'(1);
         if (push && !pop)      cnt <= cnt + CW'(1);
         else if (pop && !push) cnt <= cnt - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         dest_q[wr_ptr] <= push_dest;
         data_q[wr_ptr] <= push_data;
      end
   end

   assign head_dest = dest_q[rd_ptr];
   assign head_data = data_q[rd_ptr];
   assign count     = cnt;

   always_comb begin
      ent_vld  = '0;
      ent_dest = '0;
      off      = '0;
      for (int i = 0; i < DEPTH; i++) begin
         off                   = PTRW'(i) - rd_ptr;
         ent_vld[i]            = (CW'(off) < cnt);
         ent_dest[i*AW +: AW]  = dest_q[i];
      end
   end
endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the RF write port between write-back (priority) and MDU results; zero-latency port mux.
// MDU backpressured by mdu_ready from registered count; head starvation raises a one-cycle stall_req.
module wb_port_arbiter #(
   parameter int DW           = 32,
   parameter int AW           = 5,
   parameter int DEPTH        = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       wb_regWrite,
   input  logic                       wb_memtoReg,
   input  logic [DW-1:0]              wb_readData,
   input  logic [DW-1:0]              wb_AluResult,
   input  logic [AW-1:0]              wb_dest,
   input  logic                       mdu_valid,
   input  logic [DW-1:0]              mdu_data,
   input  logic [AW-1:0]              mdu_dest,
   output logic                       mdu_ready,
   output logic                       rf_we,
   output logic [AW-1:0]              rf_waddr,
   output logic [DW-1:0]              rf_wdata,
   output logic                       stall_req,
   input  logic [AW-1:0]              q_rs,
   input  logic [AW-1:0]              q_rt,
   output logic                       hit_rs,
   output logic                       hit_rt,
   output logic [$clog2(DEPTH+1)-1:0] pend_count
);
   import wb_arb_pkg::*;

   localparam int CW = $clog2(DEPTH+1);
   localparam int SW = $clog2(STARVE_LIMIT+1);

   logic                fifo_empty;
   logic                pwr;
   logic                xfer;
   logic                push;
   logic                pop;
   logic [DW-1:0]       pipe_data;
   logic [AW-1:0]       head_dest;
   logic [DW-1:0]       head_data;
   logic [DEPTH-1:0]    ent_vld;
   logic [DEPTH*AW-1:0] ent_dest;
   logic [SW-1:0]       starve_cnt;
   wb_req_t             sel;

   assign fifo_empty = (pend_count == '0);
   assign mdu_ready  = rst_n && (pend_count < CW'(DEPTH));
   assign xfer       = mdu_valid && mdu_ready;
   assign push       = xfer && (mdu_dest != REG_ZERO);
   assign pwr        = wb_regWrite && (wb_dest != REG_ZERO) && !stall_req;
   assign pipe_data  = wb_memtoReg ? wb_readData : wb_AluResult;
   // An idle port with an empty FIFO takes the arriving MDU result straight through.
   assign pop        = !pwr && (!fifo_empty || push);

   wb_pend_fifo #(
      .DW    (DW),
      .AW    (AW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_dest (mdu_dest),
      .push_data (mdu_data),
      .pop       (pop),
      .head_dest (head_dest),
      .head_data (head_data),
      .count     (pend_count),
      .ent_vld   (ent_vld),
      .ent_dest  (ent_dest)
   );

   always_comb begin
      sel = '0;
      if (pwr) begin
         sel.we   = 1'b1;
         sel.addr = wb_dest;
         sel.data = pipe_data;
      end else if (!fifo_empty) begin
         sel.we   = 1'b1;
         sel.addr = head_dest;
         sel.data = head_data;
      end else if (push) begin
         sel.we   = 1'b1;
         sel.addr = mdu_dest;
         sel.data = mdu_data;
      end
   end

   assign rf_we    = rst_n && sel.we;
   assign rf_waddr = sel.addr;
   assign rf_wdata = sel.data;

   // The stall cycle always pops, so the counter restart prevents back-to-back pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt <= '0;
         stall_req  <= 1'b0;
      end else begin
         stall_req <= 1'b0;
         if (fifo_empty || pop) begin
            starve_cnt <= '0;
         end else if (starve_cnt == SW'(STARVE_LIMIT-1)) begin
            starve_cnt <= '0;
            stall_req  <= 1'b1;
         end else begin
            starve_cnt <= starve_cnt + SW'(1);
         end
      end
   end

   always_comb begin
      hit_rs = 1'b0;
      hit_rt = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (ent_vld[i] && q_rs != REG_ZERO && ent_dest[i*AW +: AW] == q_rs) hit_rs = 1'b1;
         if (ent_vld[i] && q_rt != REG_ZERO && ent_dest[i*AW +: AW] == q_rt) hit_rt = 1'b1;
      end
   end
endmodule
